branch_resolve_arbiter: RTL and testbench
=========================================

Name: branch_resolve_arbiter

Overview:
- Shares a single branch_compare datapath between two requesters, e.g. two issue slots or an execute stage plus a replay path.
- Round-robin arbitration; valid/ready handshake on both inputs and on the output.
- Two-stage pipeline: operand register (S1), then result register (S2).
- Sits in execute, feeding branch-resolution results (taken + tag) to the redirect/flush logic.

Parameters:
- XLEN, 32, operand width.
- TAG_W, 4, width of the opaque request tag carried with each compare.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_rs1 / req1_rs1  in  XLEN  first operand.
- req0_rs2 / req1_rs2  in  XLEN  second operand.
- req0_params / req1_params  in  branch_compare_params_t  branch_cond (EQ/NE/LT/GE) + unsigned_cmp.
- req0_tag / req1_tag  in  TAG_W  request tag.
- flush  in  1  kill all in-flight compares.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_taken  out  1  branch condition true.
- out_tag  out  TAG_W  tag of the result.
- out_src  out  1  requester index (0/1).

Behaviour:
- Reset (async, rst=1):
  - s1_valid=0, out_valid=0, out_taken=0, out_tag=0, out_src=0.
  - rr_last=1, so req0 wins the first contention.
- Stage advance conditions:
  - s2_free = !out_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - s1_free = !s1_valid | s1_adv.
- Arbitration (combinational):
  - Only one valid → that requester is granted.
  - Both valid → grant the requester != rr_last.
  - reqN_ready = grantN & s1_free & !flush.
  - rr_last updates to the granted index only on an accepted handshake (valid & ready).
- S1:
  - On accept, capture rs1, rs2, params, tag, src; s1_valid=1.
  - Otherwise, if s1_adv, s1_valid=0.
  - Simultaneous advance and accept → S1 reloads with the new request.
- Compare:
  - branch_compare is instantiated once, driven from S1 registers.
  - Its result is registered into S2 when s1_adv: out_valid=1, out_taken, out_tag, out_src.
- Output:
  - out_valid & out_ready with no s1_adv → out_valid=0.
  - out_taken/out_tag/out_src hold stable while out_valid & !out_ready.
- Latency and throughput:
  - Accept at edge N → out_valid high after edge N+1 (two-stage latency, result visible the cycle after S1 load).
  - Throughput 1/cycle when out_ready stays high.
- Backpressure: out_ready=0 with S1 and S2 full → both req_ready=0; no data lost or duplicated.
- Flush (synchronous, priority over all other updates):
  - Next edge: s1_valid=0, out_valid=0.
  - No accept that cycle.
  - rr_last unchanged.
  - out_taken/out_tag/out_src are don't-care while out_valid=0.
- Reset mid-operation: all in-flight entries dropped immediately; no output handshake completes.
- Operands are compared at full XLEN:
  - signed vs unsigned per params.unsigned_cmp.
  - LT/GE signed semantics use two's complement.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- When defined:
  - Extra outputs stat_taken and stat_not_taken, 32-bit each, reset to 0.
  - Incremented on each output handshake (out_valid & out_ready) per out_taken.
  - Wrap from 0xFFFFFFFF to 0.
  - Unaffected by flush.
- When undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- req0 only: rs1=5, rs2=5, EQ, tag=3, out_ready=1 → req0_ready=1; out_valid 2 cycles later with out_taken=1, out_tag=3, out_src=0.
- Both valid for 4 consecutive cycles, out_ready=1 → grants alternate 0,1,0,1 starting with req0; outputs return in the same order, one per cycle.
- rs1=0xFFFFFFFF, rs2=1, LT → out_taken=1 with unsigned_cmp=0; out_taken=0 with unsigned_cmp=1. GE gives the inverse results.
- out_ready=0 while 3 requests are offered → first two accepted, then req_ready=0. Output holds the first result stable. Releasing out_ready drains all three in order with correct tags.
- flush asserted with S1 and S2 full → out_valid=0 next cycle; no accept in the flush cycle; the next request after flush produces a correct result; arbitration order continues from the pre-flush rr_last.
- With BRANCH_RESOLVE_STATS_EN: 3 taken + 2 not-taken handshakes → stat_taken=3, stat_not_taken=2. A result flushed before handshake is not counted; async rst clears both counters.

Source files
------------

// File: rtl/branch_resolve_arbiter.sv
// branch_resolve_arbiter: two requesters share one branch_compare datapath.
// Round-robin grant, S1 operand register, S2 result register.
// Optional macro BRANCH_RESOLVE_STATS_EN adds taken/not-taken handshake counters.
//
// Handshake rule for every port pair: a transfer happens on a rising edge
// where valid & ready are both high. A producer holds valid and its payload
// stable until that transfer. Ready may depend on valid.

package branch_resolve_pkg;
  typedef enum logic [1:0] {
    BR_EQ = 2'd0,
    BR_NE = 2'd1,
    BR_LT = 2'd2,
    BR_GE = 2'd3
  } branch_cond_t;

  typedef struct packed {
    branch_cond_t branch_cond;
    logic         unsigned_cmp;
  } branch_compare_params_t;
endpackage

// Full-width compare; LT/GE honour unsigned_cmp, else two's complement.
module branch_compare
  import branch_resolve_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]        rs1,
  input  logic [XLEN-1:0]        rs2,
  input  branch_compare_params_t params,
  output logic                   taken
);
  logic eq;
  logic lt;

  // Evaluate the selected condition.
  always_comb begin
    eq    = (rs1 == rs2);
    lt    = params.unsigned_cmp ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
    taken = 1'b0;
    case (params.branch_cond)
      BR_EQ:   taken = eq;
      BR_NE:   taken = !eq;
      BR_LT:   taken = lt;
      BR_GE:   taken = !lt;
      default: taken = 1'b0;
    endcase
  end
endmodule

module branch_resolve_arbiter
  import branch_resolve_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [XLEN-1:0]        req0_rs1,
  input  logic [XLEN-1:0]        req0_rs2,
  input  branch_compare_params_t req0_params,
  input  logic [TAG_W-1:0]       req0_tag,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [XLEN-1:0]        req1_rs1,
  input  logic [XLEN-1:0]        req1_rs2,
  input  branch_compare_params_t req1_params,
  input  logic [TAG_W-1:0]       req1_tag,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_taken,
  output logic [TAG_W-1:0]       out_tag,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [31:0]            stat_taken,
  output logic [31:0]            stat_not_taken,
`endif
  output logic                   out_src
);
  logic                   rr_last;
  logic                   s1_valid;
  logic [XLEN-1:0]        s1_rs1;
  logic [XLEN-1:0]        s1_rs2;
  branch_compare_params_t s1_params;
  logic [TAG_W-1:0]       s1_tag;
  logic                   s1_src;

  logic s2_free, s1_adv, s1_free;
  logic grant0, grant1, accept, cmp_taken;

  // Pipeline advance terms and round-robin grant (req0 wins when rr_last=1).
  always_comb begin
    s2_free    = !out_valid || out_ready;
    s1_adv     = s1_valid && s2_free;
    s1_free    = !s1_valid || s1_adv;
    grant0     = req0_valid && (!req1_valid || rr_last);
    grant1     = req1_valid && (!req0_valid || !rr_last);
    req0_ready = grant0 && s1_free && !flush;
    req1_ready = grant1 && s1_free && !flush;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  end

  // Remember the last accepted requester; untouched by flush (ready is low then).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_last <= 1'b1;
    else if (accept) rr_last <= grant1;
  end

  // S1 operand register: flush kills, accept reloads, advance empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_params <= '0;
      s1_tag    <= '0;
      s1_src    <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_rs1    <= grant1 ? req1_rs1 : req0_rs1;
      s1_rs2    <= grant1 ? req1_rs2 : req0_rs2;
      s1_params <= grant1 ? req1_params : req0_params;
      s1_tag    <= grant1 ? req1_tag : req0_tag;
      s1_src    <= grant1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .rs1    (s1_rs1),
    .rs2    (s1_rs2),
    .params (s1_params),
    .taken  (cmp_taken)
  );

  // S2 result register: payload only changes when a new result moves in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_taken <= 1'b0;
      out_tag   <= '0;
      out_src   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_taken <= cmp_taken;
      out_tag   <= s1_tag;
      out_src   <= s1_src;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  // Count completed output handshakes by outcome; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else if (out_valid && out_ready) begin
      if (out_taken) stat_taken     <= stat_taken + 32'd1;
      else           stat_not_taken <= stat_not_taken + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_arbiter.sv
// Directed bench for branch_resolve_arbiter: vector table plus hand sequences
// for backpressure, flush and mid-operation reset. A negedge monitor keeps an
// expected queue of {taken, src, tag} pushed at accept and popped at output.
module tb_branch_resolve_arbiter;
  import branch_resolve_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [XLEN-1:0] req0_rs1 = '0, req0_rs2 = '0, req1_rs1 = '0, req1_rs2 = '0;
  branch_compare_params_t req0_params = '0, req1_params = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic flush = 1'b0;
  logic out_valid, out_ready = 1'b0, out_taken, out_src;
  logic [TAG_W-1:0] out_tag;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_taken, stat_not_taken;
`endif

  branch_resolve_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1),
    .req0_rs2(req0_rs2), .req0_params(req0_params), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1),
    .req1_rs2(req1_rs2), .req1_params(req1_params), .req1_tag(req1_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_tag(out_tag),
`ifdef BRANCH_RESOLVE_STATS_EN
    .stat_taken(stat_taken), .stat_not_taken(stat_not_taken),
`endif
    .out_src(out_src)
  );

  // Clock
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_q[$];           // {taken, src, tag}
  logic cur_exp0 = 1'b0, cur_exp1 = 1'b0;
  int exp_stat_t = 0, exp_stat_nt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic src, input logic [31:0] a, input logic [31:0] b,
                       input branch_cond_t c, input logic u, input logic [3:0] tag,
                       input logic exp);
    if (src) begin
      req1_valid = 1'b1; req1_rs1 = a; req1_rs2 = b; req1_tag = tag;
      req1_params = '{branch_cond: c, unsigned_cmp: u}; cur_exp1 = exp;
    end else begin
      req0_valid = 1'b1; req0_rs1 = a; req0_rs2 = b; req0_tag = tag;
      req0_params = '{branch_cond: c, unsigned_cmp: u}; cur_exp0 = exp;
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      cyc();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: accepts push, output handshakes pop and compare.
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid && req0_ready) exp_q.push_back({cur_exp0, 1'b0, req0_tag});
      if (req1_valid && req1_ready) exp_q.push_back({cur_exp1, 1'b1, req1_tag});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          chk("sb_result", {26'd0, out_taken, out_src, out_tag}, {26'd0, e});
          if (e[5]) exp_stat_t++;
          else exp_stat_nt++;
        end
      end
    end
  end

  typedef struct {
    logic         src;
    logic [31:0]  rs1;
    logic [31:0]  rs2;
    branch_cond_t cond;
    logic         uns;
    logic [3:0]   tag;
    logic         exp_taken;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 32'd5,          32'd5,          BR_EQ, 1'b0, 4'd3,  1'b1};
    vecs[1]  = '{1'b0, 32'd5,          32'd5,          BR_NE, 1'b0, 4'd4,  1'b0};
    vecs[2]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          BR_LT, 1'b0, 4'd5,  1'b1};
    vecs[3]  = '{1'b1, 32'hFFFFFFFF,   32'd1,          BR_LT, 1'b1, 4'd6,  1'b0};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          BR_GE, 1'b0, 4'd7,  1'b0};
    vecs[5]  = '{1'b1, 32'hFFFFFFFF,   32'd1,          BR_GE, 1'b1, 4'd8,  1'b1};
    vecs[6]  = '{1'b0, 32'd7,          32'd8,          BR_EQ, 1'b0, 4'd9,  1'b0};
    vecs[7]  = '{1'b1, 32'h80000000,   32'h7FFFFFFF,   BR_LT, 1'b0, 4'd10, 1'b1};
    vecs[8]  = '{1'b0, 32'h80000000,   32'h7FFFFFFF,   BR_LT, 1'b1, 4'd11, 1'b0};
    vecs[9]  = '{1'b1, 32'h1234,       32'h1234,       BR_GE, 1'b0, 4'd12, 1'b1};
    vecs[10] = '{1'b0, 32'd1,          32'd2,          BR_NE, 1'b1, 4'd13, 1'b1};
    vecs[11] = '{1'b1, 32'hFFFFFFFE,   32'hFFFFFFFF,   BR_LT, 1'b0, 4'd15, 1'b1};

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_taken", {31'd0, out_taken}, 32'd0);
    chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_out_src", {31'd0, out_src}, 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("rst_stat_t", stat_taken, 32'd0);
    chk("rst_stat_nt", stat_not_taken, 32'd0);
`endif
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    cyc();

    // Table: single request, two-cycle latency, result fields
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].src, vecs[i].rs1, vecs[i].rs2, vecs[i].cond, vecs[i].uns,
            vecs[i].tag, vecs[i].exp_taken);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i),
          {31'd0, vecs[i].src ? req1_ready : req0_ready}, 32'd1);
      cyc();
      idle();
      @(negedge clk);
      chk($sformatf("vec%0d_early", i), {31'd0, out_valid}, 32'd0);
      cyc();
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_taken", i), {31'd0, out_taken}, {31'd0, vecs[i].exp_taken});
      chk($sformatf("vec%0d_tag", i), {28'd0, out_tag}, {28'd0, vecs[i].tag});
      chk($sformatf("vec%0d_src", i), {31'd0, out_src}, {31'd0, vecs[i].src});
      cyc();
    end
    drain("table_drain");

    // Async reset mid-operation drops the in-flight result at once
    out_ready = 1'b0;
    drive(1'b0, 32'd2, 32'd2, BR_EQ, 1'b0, 4'd14, 1'b1);
    cyc();
    idle();
    cyc();
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_tag", {28'd0, out_tag}, 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("async_rst_stat_t", stat_taken, 32'd0);
    chk("async_rst_stat_nt", stat_not_taken, 32'd0);
`endif
    exp_q.delete();
    exp_stat_t = 0;
    exp_stat_nt = 0;
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;

    // Contention right after reset: 0,1,0,1 then back-to-back outputs
    drive(1'b0, 32'd1, 32'd1, BR_EQ, 1'b0, 4'hA, 1'b1);
    drive(1'b1, 32'd1, 32'd2, BR_EQ, 1'b0, 4'hB, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 4) idle();
      @(negedge clk);
      if (k < 4) begin
        chk($sformatf("rr%0d_ready0", k), {31'd0, req0_ready}, {31'd0, (k % 2) == 0});
        chk($sformatf("rr%0d_ready1", k), {31'd0, req1_ready}, {31'd0, (k % 2) == 1});
      end
      if (k >= 2) chk($sformatf("rr%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
      cyc();
    end
    drain("rr_drain");

    // Backpressure: two accepted, third stalls, output holds, then drains in order
    out_ready = 1'b0;
    drive(1'b0, 32'd9, 32'd9, BR_EQ, 1'b0, 4'd1, 1'b1);
    @(negedge clk);
    chk("bp_ready_a", {31'd0, req0_ready}, 32'd1);
    cyc();
    drive(1'b0, 32'd9, 32'd9, BR_NE, 1'b0, 4'd2, 1'b0);
    @(negedge clk);
    chk("bp_ready_b", {31'd0, req0_ready}, 32'd1);
    cyc();
    drive(1'b0, 32'd1, 32'd2, BR_LT, 1'b1, 4'd3, 1'b1);
    @(negedge clk);
    chk("bp_stall_c", {31'd0, req0_ready}, 32'd0);
    chk("bp_out_tag", {28'd0, out_tag}, 32'd1);
    cyc();
    @(negedge clk);
    chk("bp_stall_c2", {31'd0, req0_ready}, 32'd0);
    chk("bp_hold_tag", {28'd0, out_tag}, 32'd1);
    chk("bp_hold_taken", {31'd0, out_taken}, 32'd1);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_c", {31'd0, req0_ready}, 32'd1);
    cyc();
    idle();
    drain("bp_drain");

    // Flush with S1 and S2 full; rr_last (req0) survives, so req1 wins next
    out_ready = 1'b0;
    drive(1'b0, 32'd4, 32'd4, BR_EQ, 1'b0, 4'd4, 1'b1);
    cyc();
    drive(1'b0, 32'd4, 32'd5, BR_NE, 1'b0, 4'd5, 1'b1);
    cyc();
    flush = 1'b1;
    drive(1'b0, 32'd6, 32'd6, BR_EQ, 1'b0, 4'd6, 1'b1);
    drive(1'b1, 32'd3, 32'd9, BR_LT, 1'b0, 4'd7, 1'b1);
    @(negedge clk);
    chk("fl_full", {31'd0, out_valid}, 32'd1);
    chk("fl_ready0", {31'd0, req0_ready}, 32'd0);
    chk("fl_ready1", {31'd0, req1_ready}, 32'd0);
    cyc();
    flush = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_rr_ready1", {31'd0, req1_ready}, 32'd1);
    chk("fl_rr_ready0", {31'd0, req0_ready}, 32'd0);
    cyc();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("fl_s1_empty", {31'd0, out_valid}, 32'd0);
    chk("fl_next_ready0", {31'd0, req0_ready}, 32'd1);
    cyc();
    idle();
    @(negedge clk);
    chk("fl_res_valid", {31'd0, out_valid}, 32'd1);
    chk("fl_res_tag", {28'd0, out_tag}, 32'd7);
    chk("fl_res_src", {31'd0, out_src}, 32'd1);
    chk("fl_res_taken", {31'd0, out_taken}, 32'd1);
    cyc();
    drain("fl_drain");

`ifdef BRANCH_RESOLVE_STATS_EN
    @(negedge clk);
    chk("stat_taken", stat_taken, exp_stat_t);
    chk("stat_not_taken", stat_not_taken, exp_stat_nt);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
